// File: rtl/meas_mem_writer_pkg.sv
// Shared constants and state encoding for the measurement memory path.
// The measurement reader and the memory model import the same definitions.
package meas_mem_writer_pkg;

    // Default frame geometry
    localparam int C_IOSCNUM_DEF      = 48;
    localparam int C_IOSCDWIDTH_DEF   = 24;
    localparam int C_MEMDATAWIDTH_DEF = 8;
    localparam int C_MEMADDRWIDTH_DEF = 24;

    // Writer FSM encoding; IDLE is all-zero so reset and IDLE coincide
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } meas_state_t;

endpackage

// File: rtl/meas_byte_ser.sv
// Result-to-byte serializer: loads one count result, presents its low byte,
// and shifts the next byte down on request. The last flag marks the final byte.
module meas_byte_ser #(
    parameter int DW = 24,
    parameter int BW = 8,
    parameter int NB = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          shift,
    input  logic [DW-1:0] din,
    output logic [BW-1:0] byte_out,
    output logic          last
);

    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    logic [DW-1:0] shreg_q;
    logic [CW-1:0] cnt_q;

    // Load a fresh result or move the next byte into the low lane
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            shreg_q <= din;
            cnt_q   <= '0;
        end else if (shift) begin
            shreg_q <= shreg_q >> BW;
            cnt_q   <= cnt_q + CW'(1);
        end
    end

    assign byte_out = shreg_q[BW-1:0];
    assign last     = (cnt_q == CW'(NB - 1));

endmodule

// File: rtl/meas_mem_writer.sv
// Measurement frame writer: accepts count results over a valid/ready port and
// writes each one to memory as consecutive bytes, LSB byte first, starting at
// a base address latched with the frame start pulse.
//
// Handshake: a result transfers on a rising edge where I_res_valid and
// O_res_ready are both high; the source holds I_res_data stable until then.
// O_res_ready is high only in ACCEPT. I_start takes priority over everything:
// a start in the same cycle as valid/ready discards that result.
module meas_mem_writer
    import meas_mem_writer_pkg::*;
#(
    parameter int C_IOSCNUM      = C_IOSCNUM_DEF,
    parameter int C_IOSCDWIDTH   = C_IOSCDWIDTH_DEF,
    parameter int C_MEMDATAWIDTH = C_MEMDATAWIDTH_DEF,
    parameter int C_MEMADDRWIDTH = C_MEMADDRWIDTH_DEF
) (
    input  logic                      I_sclk,
    input  logic                      I_rst_n,
    input  logic                      I_start,
    input  logic [C_MEMADDRWIDTH-1:0] I_base_addr,
    input  logic                      I_res_valid,
    input  logic [C_IOSCDWIDTH-1:0]   I_res_data,
    output logic                      O_res_ready,
    output logic [C_MEMADDRWIDTH-1:0] O_mem_addr,
    output logic [C_MEMDATAWIDTH-1:0] O_mem_data,
    output logic                      O_mem_we,
    output logic                      O_busy,
    output logic                      O_done,
    output logic [1:0]                O_state
);

    localparam int NB  = C_IOSCDWIDTH / C_MEMDATAWIDTH;
    localparam int RCW = $clog2(C_IOSCNUM + 1);

    // A result must split into a whole number of memory words
    generate
        if ((C_IOSCDWIDTH % C_MEMDATAWIDTH) != 0 || NB < 1) begin : g_bad_width
            $error("meas_mem_writer: C_IOSCDWIDTH must be a multiple of C_MEMDATAWIDTH");
        end
    endgenerate

    meas_state_t               state_q, state_d;
    logic [C_MEMADDRWIDTH-1:0] ptr_q;
    logic [C_MEMADDRWIDTH-1:0] addr_q;
    logic [RCW-1:0]            res_cnt_q;
    logic                      ser_load;
    logic                      ser_shift;
    logic                      ser_last;
    logic [C_MEMDATAWIDTH-1:0] ser_byte;

    meas_byte_ser #(
        .DW (C_IOSCDWIDTH),
        .BW (C_MEMDATAWIDTH),
        .NB (NB)
    ) u_ser (
        .clk      (I_sclk),
        .rst_n    (I_rst_n),
        .load     (ser_load),
        .shift    (ser_shift),
        .din      (I_res_data),
        .byte_out (ser_byte),
        .last     (ser_last)
    );

    // State register
    always_ff @(posedge I_sclk) begin
        if (!I_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state and serializer control; start aborts from any state
    always_comb begin
        state_d   = state_q;
        ser_load  = 1'b0;
        ser_shift = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (I_start) state_d = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                if (I_start) begin
                    state_d = ST_ACCEPT;
                end else if (I_res_valid) begin
                    state_d  = ST_WRITE;
                    ser_load = 1'b1;
                end
            end
            ST_WRITE: begin
                if (I_start) begin
                    state_d = ST_ACCEPT;
                end else if (ser_last) begin
                    state_d = (res_cnt_q == RCW'(C_IOSCNUM - 1)) ? ST_DONE : ST_ACCEPT;
                end else begin
                    ser_shift = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = I_start ? ST_ACCEPT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Address pointer, registered write address and result counter.
    // addr_q is only updated when a byte is about to be written, so it holds
    // its value while the write strobe is low.
    always_ff @(posedge I_sclk) begin
        if (!I_rst_n) begin
            ptr_q     <= '0;
            addr_q    <= '0;
            res_cnt_q <= '0;
        end else if (I_start) begin
            ptr_q     <= I_base_addr;
            res_cnt_q <= '0;
        end else begin
            if (ser_load || ser_shift) begin
                addr_q <= ptr_q;
                ptr_q  <= ptr_q + C_MEMADDRWIDTH'(1);
            end
            if (state_q == ST_WRITE && ser_last) begin
                res_cnt_q <= res_cnt_q + RCW'(1);
            end
        end
    end

    assign O_res_ready = (state_q == ST_ACCEPT);
    assign O_mem_we    = (state_q == ST_WRITE);
    assign O_busy      = (state_q == ST_ACCEPT) || (state_q == ST_WRITE);
    assign O_done      = (state_q == ST_DONE);
    assign O_mem_addr  = addr_q;
    assign O_mem_data  = ser_byte;
    assign O_state     = state_q;

endmodule

// File: doc/meas_mem_writer.md
MEAS_MEM_WRITER -- requirements
Module: meas_mem_writer

Interface
REQ-001 SHALL have parameter C_IOSCNUM, default 48: oscillator results per frame.
REQ-002 SHALL have parameter C_IOSCDWIDTH, default 24: width of one count result.
REQ-003 SHALL have parameter C_MEMDATAWIDTH, default 8: memory write-data width.
REQ-004 SHALL have parameter C_MEMADDRWIDTH, default 24: memory address width.
REQ-005 SHALL have port I_sclk, input, 1: sole clock; all logic on its rising edge.
REQ-006 SHALL have port I_rst_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port I_start, input, 1: one-cycle pulse that opens a frame.
REQ-008 SHALL have port I_base_addr, input, C_MEMADDRWIDTH: frame start address, sampled with I_start.
REQ-009 SHALL have port I_res_valid, input, 1: a count result is presented.
REQ-010 SHALL have port I_res_data, input, C_IOSCDWIDTH: count result.
REQ-011 SHALL have port O_res_ready, output, 1: the block accepts I_res_data this cycle.
REQ-012 SHALL have port O_mem_addr, output, C_MEMADDRWIDTH: memory write address.
REQ-013 SHALL have port O_mem_data, output, C_MEMDATAWIDTH: memory write data.
REQ-014 SHALL have port O_mem_we, output, 1: write strobe, one byte per asserted cycle.
REQ-015 SHALL have port O_busy, output, 1: a frame is open.
REQ-016 SHALL have port O_done, output, 1: one-cycle pulse after the last byte of a frame.

Function
REQ-017 SHALL define NB = C_IOSCDWIDTH/C_MEMDATAWIDTH; C_IOSCDWIDTH not an integer multiple of C_MEMDATAWIDTH is an elaboration error.
REQ-018 SHALL implement states IDLE, ACCEPT, WRITE, DONE.
REQ-019 IDLE: O_res_ready=0; I_start -> latch I_base_addr into the address pointer, clear the result counter, go to ACCEPT.
REQ-020 ACCEPT: O_res_ready=1; a handshake (I_res_valid and O_res_ready) captures I_res_data into a shift register, clears the byte counter, and moves to WRITE.
REQ-021 WRITE: O_res_ready=0; one byte per cycle, LSB byte first; O_mem_we=1; O_mem_data=current low byte; O_mem_addr=pointer; pointer increments after each byte.
REQ-022 After byte NB-1: increment the result counter; if it reaches C_IOSCNUM go to DONE, else return to ACCEPT.
REQ-023 DONE: O_done=1 for exactly one cycle, then IDLE.
REQ-024 Outputs SHALL be registered: the first byte of a result appears on the memory port the cycle after the handshake; a frame takes C_IOSCNUM*(NB+1)+1 cycles at full input rate.
REQ-025 Address pointer SHALL wrap modulo 2^C_MEMADDRWIDTH without error.
REQ-026 Result i SHALL land at base+i*NB .. base+i*NB+NB-1.
REQ-027 I_start outside IDLE SHALL abort the frame: no further bytes for the old frame, no O_done, re-latch I_base_addr, enter ACCEPT next cycle.
REQ-028 I_res_valid while O_res_ready=0 SHALL be ignored; the source holds data until it is accepted.
REQ-029 O_busy SHALL be 1 in ACCEPT and WRITE and 0 in IDLE and DONE.
REQ-030 O_mem_addr and O_mem_data SHALL hold their last values when O_mem_we=0.

Reset
REQ-031 While I_rst_n=0 at a clock edge: state IDLE; O_res_ready, O_mem_we, O_busy, O_done=0; O_mem_addr, O_mem_data, counters, and the shift register=0.
REQ-032 Reset mid-frame SHALL discard the frame with no further write strobes.

Structure
REQ-033 Shared package SHALL hold the default width/count constants (48, 24, 8, 24) and the state encoding, shared with the measurement reader and the memory model.
REQ-034 A single sub-module meas_byte_ser (load, shift-out, last-byte flag) is natural; all other logic is flat.

Verification
REQ-035 Reset, base 0x000010, 48 results r_i=0x0A0B00+i at full rate -> 144 writes with addr 0x10+3i = {00+i, 0B, 0A}; O_done pulses once at cycle 2+48*4.
REQ-036 Result 0x123456 with I_res_valid held through WRITE -> accepted exactly once; bytes 56,34,12.
REQ-037 Base 0xFFFFFE, one result 0xAABBCC -> writes CC@FFFFFE, BB@FFFFFF, AA@000000.
REQ-038 I_start with base 0x100 pulsed after 5 results (in WRITE) -> no more writes at the old addresses; the next result is written at 0x100; only one O_done.
REQ-039 I_rst_n=0 during byte 1 of result 3 -> next cycle O_mem_we=0, O_busy=0, all outputs 0; no O_done.
REQ-040 I_res_valid pulsed in IDLE with no start -> no handshake and no writes.
